// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

    // Arbitration mode: CPU priority, or DMA forced after starvation.
    typedef enum logic {
        ARB_CPU       = 1'b0,
        ARB_DMA_FORCE = 1'b1
    } arb_state_t;

    // Requester indices into the grant vector.
    localparam int PORT_CPU  = 0;
    localparam int PORT_DMA  = 1;
    localparam int NUM_PORTS = 2;

    // Width of the DMA starvation counter; supports limits up to 15.
    localparam int STARVE_CW = 4;

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating count of consecutive denied DMA cycles, with clear.
// Latency: count updates at the clock edge; limit_next_o is combinational.
// Backpressure: none; it only observes the DMA grant/deny outcome.
module dmem_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic limit_next_o
);

    localparam logic [STARVE_CW-1:0] LIM = STARVE_CW'(LIMIT);

    logic [STARVE_CW-1:0] cnt_q;
    logic [STARVE_CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flagging the edge at which the limit is reached lets the arbiter
    // switch mode in time for the very next cycle.
    assign limit_next_o = (cnt_d == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Grants one of CPU / DMA per cycle to the single-port data memory; registered read return.
// Latency: grant combinational in the request cycle; read data/rvalid one cycle after grant.
// Backpressure: ungranted requester sees ready=0 (CPU also sees stall); optional anti-starvation via DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRESS_LINE = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDRESS_LINE-1:0] cpu_addr,
    input  logic [7:0]              cpu_wdata,
    output logic                    cpu_ready,
    output logic                    cpu_stall,
    output logic [7:0]              cpu_rdata,
    output logic                    cpu_rvalid,
    input  logic                    dma_req,
    input  logic                    dma_we,
    input  logic [ADDRESS_LINE-1:0] dma_addr,
    input  logic [7:0]              dma_wdata,
    output logic                    dma_ready,
    output logic [7:0]              dma_rdata,
    output logic                    dma_rvalid,
    output logic [ADDRESS_LINE-1:0] mem_address,
    output logic [7:0]              mem_write_data,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [7:0]              mem_read_data
);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_limit_check
        $error("STARVE_LIMIT must be within 1..15");
    end

    logic [NUM_PORTS-1:0] grant;
    logic                 dma_force;

`ifdef DMEM_ARB_STARVE_EN
    arb_state_t state_q;
    logic       limit_next;

    dmem_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk          (clock),
        .reset        (reset),
        .inc_i        (dma_req & ~grant[PORT_DMA]),
        .clr_i        (~dma_req | grant[PORT_DMA]),
        .limit_next_o (limit_next)
    );

    // Arbitration mode: force DMA once starved, release on its grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_CPU;
        end else begin
            case (state_q)
                ARB_CPU:       if (limit_next)       state_q <= ARB_DMA_FORCE;
                ARB_DMA_FORCE: if (grant[PORT_DMA])  state_q <= ARB_CPU;
                default:                             state_q <= ARB_CPU;
            endcase
        end
    end

    assign dma_force = (state_q == ARB_DMA_FORCE);
`else
    // Strict CPU priority: DMA only uses idle CPU cycles.
    assign dma_force = 1'b0;
`endif

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        grant = '0;
        if (!reset) begin
            if (dma_req && (dma_force || !cpu_req)) begin
                grant[PORT_DMA] = 1'b1;
            end else if (cpu_req) begin
                grant[PORT_CPU] = 1'b1;
            end
        end
    end

    // Memory-side mux: drive the winner's fields, all zero when idle.
    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (grant[PORT_CPU]) begin
            mem_address    = cpu_addr;
            mem_write_data = cpu_wdata;
            mem_write      = cpu_we;
            mem_read       = ~cpu_we;
        end else if (grant[PORT_DMA]) begin
            mem_address    = dma_addr;
            mem_write_data = dma_wdata;
            mem_write      = dma_we;
            mem_read       = ~dma_we;
        end
    end

    logic [7:0] cpu_rdata_q;
    logic [7:0] dma_rdata_q;
    logic       cpu_rvalid_q;
    logic       dma_rvalid_q;

    // Read return: capture memory data at the grant edge of a read.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= grant[PORT_CPU] & ~cpu_we;
            dma_rvalid_q <= grant[PORT_DMA] & ~dma_we;
            if (grant[PORT_CPU] && !cpu_we) cpu_rdata_q <= mem_read_data;
            if (grant[PORT_DMA] && !dma_we) dma_rdata_q <= mem_read_data;
        end
    end

    assign cpu_ready  = grant[PORT_CPU];
    assign dma_ready  = grant[PORT_DMA];
    assign cpu_stall  = cpu_req & ~grant[PORT_CPU];
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    // A read pending when reset arrives is dropped immediately.
    assign cpu_rvalid = cpu_rvalid_q & ~reset;
    assign dma_rvalid = dma_rvalid_q & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 256x8 data memory.
module tb_dmem_arbiter;

    logic       clock;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_ready, cpu_stall, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       dma_req, dma_we;
    logic [7:0] dma_addr, dma_wdata;
    logic       dma_ready, dma_rvalid;
    logic [7:0] dma_rdata;
    logic [7:0] mem_address, mem_write_data, mem_read_data;
    logic       mem_write, mem_read;

    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;
    logic exp_dma;

    dmem_arbiter #(.ADDRESS_LINE(8), .STARVE_LIMIT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ready      (cpu_ready),
        .cpu_stall      (cpu_stall),
        .cpu_rdata      (cpu_rdata),
        .cpu_rvalid     (cpu_rvalid),
        .dma_req        (dma_req),
        .dma_we         (dma_we),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_ready      (dma_ready),
        .dma_rdata      (dma_rdata),
        .dma_rvalid     (dma_rvalid),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address];

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
        tick();
        tick();

        // Reset state, with a CPU request present that must not be granted
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h5A;
        #3;
        check1("rst_cpu_ready", cpu_ready, 1'b0);
        check1("rst_dma_ready", dma_ready, 1'b0);
        check1("rst_mem_write", mem_write, 1'b0);
        check1("rst_mem_read", mem_read, 1'b0);
        check8("rst_mem_address", mem_address, 8'h00);
        check8("rst_mem_wdata", mem_write_data, 8'h00);
        check1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check8("rst_cpu_rdata", cpu_rdata, 8'h00);
        check8("rst_dma_rdata", dma_rdata, 8'h00);
        tick();
        reset = 1'b0;

        // CPU write 0x5A to 0x10
        #3;
        check1("wr_cpu_ready", cpu_ready, 1'b1);
        check1("wr_cpu_stall", cpu_stall, 1'b0);
        check1("wr_mem_write", mem_write, 1'b1);
        check1("wr_mem_read", mem_read, 1'b0);
        check8("wr_mem_address", mem_address, 8'h10);
        check8("wr_mem_wdata", mem_write_data, 8'h5A);
        tick();
        // CPU read of 0x10 right after the write
        cpu_we = 1'b0;
        #3;
        check1("rd_after_wr_rvalid", cpu_rvalid, 1'b0);
        check1("rd_cpu_ready", cpu_ready, 1'b1);
        check1("rd_mem_read", mem_read, 1'b1);
        tick();
        cpu_req = 1'b0;
        #3;
        check1("rd_cpu_rvalid", cpu_rvalid, 1'b1);
        check8("rd_cpu_rdata", cpu_rdata, 8'h5A);
        check1("idle_mem_read", mem_read, 1'b0);
        tick();
        #3;
        check1("rd_rvalid_pulse", cpu_rvalid, 1'b0);
        check8("rd_rdata_hold", cpu_rdata, 8'h5A);

        // DMA write 0xC3 to 0x20, then DMA read of 0x20
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 8'hC3;
        #3;
        check1("dwr_dma_ready", dma_ready, 1'b1);
        tick();
        dma_we = 1'b0;
        #3;
        check1("drd_dma_ready", dma_ready, 1'b1);
        check1("drd_mem_read", mem_read, 1'b1);
        check8("drd_mem_address", mem_address, 8'h20);
        tick();
        dma_req = 1'b0;
        #3;
        check1("drd_dma_rvalid", dma_rvalid, 1'b1);
        check8("drd_dma_rdata", dma_rdata, 8'hC3);
        check1("drd_cpu_rvalid", cpu_rvalid, 1'b0);
        tick();

        // Both ports requesting continuously
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
        for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_STARVE_EN
            exp_dma = ((i % 5) == 4);
`else
            exp_dma = 1'b0;
`endif
            #3;
            check1($sformatf("arb_dma_ready[%0d]", i), dma_ready, exp_dma);
            check1($sformatf("arb_cpu_ready[%0d]", i), cpu_ready, ~exp_dma);
            check1($sformatf("arb_cpu_stall[%0d]", i), cpu_stall, exp_dma);
            tick();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();

        // Both write 0x33: CPU first (0x11), DMA next cycle (0x22)
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 8'h11;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h33; dma_wdata = 8'h22;
        #3;
        check1("ww_cpu_ready", cpu_ready, 1'b1);
        check1("ww_dma_denied", dma_ready, 1'b0);
        check8("ww_cpu_wdata", mem_write_data, 8'h11);
        tick();
        cpu_req = 1'b0;
        #3;
        check1("ww_dma_ready", dma_ready, 1'b1);
        check8("ww_dma_wdata", mem_write_data, 8'h22);
        tick();
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33;
        #3;
        check1("ww_rd_ready", cpu_ready, 1'b1);
        tick();
        cpu_req = 1'b0;
        #3;
        check1("ww_rd_rvalid", cpu_rvalid, 1'b1);
        check8("ww_rd_rdata", cpu_rdata, 8'h22);

        // Reset in the cycle after a CPU read grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        tick();
        reset = 1'b1;
        #3;
        check1("mrst_cpu_rvalid", cpu_rvalid, 1'b0);
        check1("mrst_cpu_ready", cpu_ready, 1'b0);
        check1("mrst_mem_read", mem_read, 1'b0);
        check1("mrst_mem_write", mem_write, 1'b0);
        check8("mrst_mem_address", mem_address, 8'h00);
        check8("mrst_mem_wdata", mem_write_data, 8'h00);
        tick();
        #3;
        check1("mrst_cpu_rvalid_after", cpu_rvalid, 1'b0);
        check8("mrst_cpu_rdata", cpu_rdata, 8'h00);
        check8("mrst_dma_rdata", dma_rdata, 8'h00);
        cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Starve counter restarts when DMA drops its request
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
        for (int i = 0; i < 3; i++) begin
            #3;
            check1($sformatf("sr_pre_dma_ready[%0d]", i), dma_ready, 1'b0);
            tick();
        end
        dma_req = 1'b0;
        #3;
        check1("sr_gap_cpu_ready", cpu_ready, 1'b1);
        tick();
        dma_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
`ifdef DMEM_ARB_STARVE_EN
            exp_dma = (i == 4);
`else
            exp_dma = 1'b0;
`endif
            #3;
            check1($sformatf("sr_post_dma_ready[%0d]", i), dma_ready, exp_dma);
            tick();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
